// File: rtl/cp0_nested_intc_if.sv
// Bus between the CPU pipeline and cp0_nested_intc.
// Carries the mfc0/mtc0 register ports, the interrupt lines and the
// request/acknowledge/eret handshake. The slave modport is the controller's
// view, the master modport is the CPU/pipeline view.
interface cp0_nested_intc_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_IRQ = 4
) ();
  logic [4:0]         R_in;
  logic [WIDTH-1:0]   R_out;
  logic [4:0]         W_in;
  logic [WIDTH-1:0]   Din;
  logic               WE;
  logic [NUM_IRQ-1:0] irq;
  logic               int_req;
  logic [WIDTH-1:0]   int_vector;
  logic               int_ack;
  logic [WIDTH-1:0]   EPC_in;
  logic               eret;
  logic [WIDTH-1:0]   EPC_out;

  modport slave (
    input  R_in, W_in, Din, WE, irq, int_ack, EPC_in, eret,
    output R_out, int_req, int_vector, EPC_out
  );

  modport master (
    output R_in, W_in, Din, WE, irq, int_ack, EPC_in, eret,
    input  R_out, int_req, int_vector, EPC_out
  );
endinterface

// File: rtl/cp0_nested_intc.sv
// Coprocessor-0 nested interrupt controller.
// Prioritised level interrupt lines with edge-captured sticky pending bits,
// per-line mask, in-service register and an EPC stack for nested handlers.
// Ports:
//   clk    - rising-edge clock
//   clr_n  - asynchronous active-low reset
//   bus    - slave side of cp0_nested_intc_if:
//            R_in/R_out   register read (R_out combinational)
//            W_in/Din/WE  register write
//            irq          interrupt lines (line 0 highest priority)
//            int_req/int_vector/int_ack  request handshake (registered outputs)
//            EPC_in       return address pushed on acceptance
//            eret         return-from-handler pulse
//            EPC_out      top of EPC stack, 0 when empty
// Register map: 12 Status, 13 Cause, 14 EPC; all other numbers read 0.
module cp0_nested_intc #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     NUM_IRQ    = 4,
  parameter int unsigned     EPC_DEPTH  = 4,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_0100),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(32'h0000_0010)
) (
  input  logic              clk,
  input  logic              clr_n,
  cp0_nested_intc_if.slave  bus
);

  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned PW = $clog2(EPC_DEPTH);
  localparam int unsigned DW = PW + 1;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t             state;
  logic               ie;
  logic [NUM_IRQ-1:0] im;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] isr;
  logic               stkerr;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [DW-1:0]      depth;
  logic [WIDTH-1:0]   stk [EPC_DEPTH];
  logic [IW-1:0]      k_q;
  logic               int_req_q;
  logic [WIDTH-1:0]   int_vector_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [IW-1:0]      hi_idx;
  logic [IW-1:0]      isr_lo_idx;
  logic               isr_any;
  logic               eligible;
  logic               ack_fire;
  logic               eret_fire;
  logic               eret_err;
  logic               pop;
  logic               sw_status;
  logic               sw_cause;
  logic               sw_epc;
  logic [PW-1:0]      top_idx;
  logic [NUM_IRQ-1:0] ip_n;
  logic [NUM_IRQ-1:0] isr_n;
  logic               ie_n;
  logic [WIDTH-1:0]   status_val;
  logic [WIDTH-1:0]   cause_val;
  logic [WIDTH-1:0]   epc_top;
  logic               unused_din;

  // Only a subset of Din bits lands in writable fields.
  assign unused_din = ^bus.Din;

  assign rise      = bus.irq & ~irq_prev;
  assign cand      = ip & im & ~isr;
  assign isr_any   = |isr;
  assign sw_status = bus.WE && (bus.W_in == REG_STATUS);
  assign sw_cause  = bus.WE && (bus.W_in == REG_CAUSE);
  assign sw_epc    = bus.WE && (bus.W_in == REG_EPC);
  assign top_idx   = PW'(depth - DW'(1));
  assign epc_top   = (depth == '0) ? '0 : stk[top_idx];

  // An ack in REQ takes precedence; a coinciding eret is dropped and flagged.
  assign ack_fire  = (state == S_REQ) && bus.int_ack;
  assign eret_fire = bus.eret && !ack_fire;
  assign eret_err  = bus.eret && (ack_fire || (depth == '0));
  assign pop       = eret_fire && (depth != '0);

  // Lowest-index (highest-priority) candidate and lowest in-service line.
  always_comb begin
    logic found_c;
    logic found_s;
    hi_idx     = '0;
    isr_lo_idx = '0;
    found_c    = 1'b0;
    found_s    = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && !found_c) begin
        hi_idx  = IW'(i);
        found_c = 1'b1;
      end
      if (isr[i] && !found_s) begin
        isr_lo_idx = IW'(i);
        found_s    = 1'b1;
      end
    end
  end

  assign eligible = ie && (|cand) && (!isr_any || (hi_idx < isr_lo_idx)) &&
                    (depth < DW'(EPC_DEPTH));

  // Next values of pending, in-service and IE; hardware events win over software.
  always_comb begin
    ip_n = ip;
    if (sw_cause) ip_n = ip_n & bus.Din[8 +: NUM_IRQ];
    if (ack_fire) ip_n[k_q] = 1'b0;
    ip_n = ip_n | rise;

    isr_n = isr;
    if (ack_fire) isr_n[k_q] = 1'b1;
    else if (eret_fire && isr_any) isr_n[isr_lo_idx] = 1'b0;

    ie_n = ie;
    if (sw_status) ie_n = bus.Din[0];
    if (ack_fire) ie_n = 1'b0;
    else if (bus.eret) ie_n = 1'b1;
  end

  // Request/acknowledge FSM and all control registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= S_IDLE;
      ie           <= 1'b0;
      im           <= '1;
      ip           <= '0;
      isr          <= '0;
      stkerr       <= 1'b0;
      irq_prev     <= '0;
      k_q          <= '0;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
    end else begin
      irq_prev <= bus.irq;
      ip       <= ip_n;
      isr      <= isr_n;
      ie       <= ie_n;
      stkerr   <= stkerr | eret_err;
      if (sw_status) im <= bus.Din[8 +: NUM_IRQ];
      case (state)
        S_IDLE: begin
          if (eligible) begin
            state        <= S_REQ;
            k_q          <= hi_idx;
            int_req_q    <= 1'b1;
            int_vector_q <= VEC_BASE + WIDTH'(hi_idx) * VEC_STRIDE;
          end
        end
        S_REQ: begin
          if (bus.int_ack) begin
            state        <= S_IDLE;
            int_req_q    <= 1'b0;
            int_vector_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // EPC stack: software may overwrite the top entry, then push/pop apply.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      depth <= '0;
      for (int i = 0; i < EPC_DEPTH; i++) stk[i] <= '0;
    end else begin
      if (sw_epc && (depth != '0)) stk[top_idx] <= bus.Din;
      if (ack_fire) begin
        stk[PW'(depth)] <= bus.EPC_in;
        depth           <= depth + DW'(1);
      end else if (pop) begin
        depth <= depth - DW'(1);
      end
    end
  end

  // Register read view.
  always_comb begin
    status_val              = '0;
    status_val[0]           = ie;
    status_val[8 +: NUM_IRQ] = im;
    status_val[19:16]       = 4'(depth);

    cause_val               = '0;
    cause_val[8 +: NUM_IRQ]  = ip;
    cause_val[16 +: NUM_IRQ] = isr;
    cause_val[31]           = stkerr;

    case (bus.R_in)
      REG_STATUS: bus.R_out = status_val;
      REG_CAUSE:  bus.R_out = cause_val;
      REG_EPC:    bus.R_out = epc_top;
      default:    bus.R_out = '0;
    endcase
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vector = int_vector_q;
  assign bus.EPC_out    = epc_top;

endmodule

// File: tb/tb_cp0_nested_intc.sv
// Self-checking bench for cp0_nested_intc: register-access vector table plus
// hand-written interrupt sequences, with queued expected vectors/read data.
module tb_cp0_nested_intc;

  logic clk;
  logic clr_n;

  cp0_nested_intc_if #(.WIDTH(32), .NUM_IRQ(4)) bus ();

  cp0_nested_intc #(
    .WIDTH(32), .NUM_IRQ(4), .EPC_DEPTH(4),
    .VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'h0000_0010)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec_q [$];
  logic [31:0] rd_q  [$];

  typedef struct {
    logic        we;
    logic [4:0]  w_in;
    logic [31:0] din;
    logic [4:0]  r_in;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    bus.R_in = r;
    #1;
    v = bus.R_out;
  endtask

  task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp_v);
    logic [31:0] v;
    rd(r, v);
    chk(name, v, exp_v);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    bus.W_in = r;
    bus.Din  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] epc);
    bus.int_ack = 1'b1;
    bus.EPC_in  = epc;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  // Waits a bounded number of cycles for int_req, then pops the expected vector.
  task automatic wait_req(input string name, input int budget);
    logic [31:0] e;
    for (int i = 0; i < budget && !bus.int_req; i++) tick();
    if (!bus.int_req) begin
      checks++;
      errors++;
      $display("FAIL %s: int_req not seen within %0d cycles", name, budget);
      if (vec_q.size() > 0) void'(vec_q.pop_front());
    end else if (vec_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected request vector %h", name, bus.int_vector);
    end else begin
      e = vec_q.pop_front();
      chk(name, bus.int_vector, e);
    end
  endtask

  task automatic chk_no_req(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk(name, 32'(bus.int_req), 32'h0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] e;

    tbl[0] = '{1'b1, 5'd12, 32'h0000_0F00, 5'd12, 32'h0000_0F00};
    tbl[1] = '{1'b1, 5'd12, 32'hFFFF_FFFE, 5'd12, 32'h0000_0F00};
    tbl[2] = '{1'b1, 5'd12, 32'h0000_0501, 5'd12, 32'h0000_0501};
    tbl[3] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000};
    tbl[4] = '{1'b1, 5'd14, 32'h0000_1234, 5'd14, 32'h0000_0000};
    tbl[5] = '{1'b0, 5'd0,  32'h0000_0000, 5'd0,  32'h0000_0000};
    tbl[6] = '{1'b0, 5'd0,  32'h0000_0000, 5'd15, 32'h0000_0000};
    tbl[7] = '{1'b0, 5'd0,  32'h0000_0000, 5'd31, 32'h0000_0000};
    tbl[8] = '{1'b1, 5'd12, 32'h0000_0F00, 5'd12, 32'h0000_0F00};

    clr_n       = 1'b0;
    bus.R_in    = '0;
    bus.W_in    = '0;
    bus.Din     = '0;
    bus.WE      = 1'b0;
    bus.irq     = '0;
    bus.int_ack = 1'b0;
    bus.EPC_in  = '0;
    bus.eret    = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;

    // Reset state
    chk("rst_int_req", 32'(bus.int_req), 32'h0);
    chk("rst_int_vector", bus.int_vector, 32'h0);
    chk("rst_epc_out", bus.EPC_out, 32'h0);
    chk_reg("rst_status", 5'd12, 32'h0000_0F00);
    chk_reg("rst_cause", 5'd13, 32'h0);

    // Register access table
    for (int i = 0; i < 9; i++) begin
      bus.WE   = tbl[i].we;
      bus.W_in = tbl[i].w_in;
      bus.Din  = tbl[i].din;
      rd_q.push_back(tbl[i].exp_rd);
      tick();
      bus.WE = 1'b0;
      rd(tbl[i].r_in, v);
      e = rd_q.pop_front();
      chk($sformatf("reg_vec%0d", i), v, e);
    end

    // Single interrupt on line 2
    wr(5'd12, 32'h0000_0F01);
    bus.irq[2] = 1'b1;
    vec_q.push_back(32'h120);
    tick();
    chk_reg("a_ip2", 5'd13, 32'h0000_0400);
    chk("a_no_req_yet", 32'(bus.int_req), 32'h0);
    wait_req("a_vector", 4);
    do_ack(32'h400);
    bus.irq[2] = 1'b0;
    chk("a_epc_out", bus.EPC_out, 32'h400);
    chk("a_req_drop", 32'(bus.int_req), 32'h0);
    chk_reg("a_cause", 5'd13, 32'h0004_0000);
    chk_reg("a_status", 5'd12, 32'h0001_0F00);

    // Nesting: line 0 preempts line 2 in service
    wr(5'd12, 32'h0000_0F01);
    bus.irq[0] = 1'b1;
    vec_q.push_back(32'h100);
    wait_req("n_vector", 4);
    do_ack(32'h500);
    bus.irq[0] = 1'b0;
    chk_reg("n_status", 5'd12, 32'h0002_0F00);
    chk_reg("n_cause", 5'd13, 32'h0005_0000);
    chk("n_epc_out", bus.EPC_out, 32'h500);
    do_eret();
    chk("n_eret_epc", bus.EPC_out, 32'h400);
    chk_reg("n_eret_cause", 5'd13, 32'h0004_0000);
    chk_reg("n_eret_status", 5'd12, 32'h0001_0F01);
    do_eret();
    chk("n_eret2_epc", bus.EPC_out, 32'h0);
    chk_reg("n_eret2_cause", 5'd13, 32'h0);
    chk_reg("n_eret2_status", 5'd12, 32'h0000_0F01);

    // Simultaneous lines 1 and 3: priority order
    bus.irq[1] = 1'b1;
    bus.irq[3] = 1'b1;
    vec_q.push_back(32'h110);
    vec_q.push_back(32'h130);
    wait_req("b_first", 4);
    do_ack(32'h600);
    chk_no_req("b_ie_off", 2);
    do_eret();
    wait_req("b_second", 4);
    do_ack(32'h700);
    do_eret();
    bus.irq = '0;
    tick();
    chk_reg("b_cause_clean", 5'd13, 32'h0);

    // Masked line 1 pends but does not request until unmasked
    wr(5'd12, 32'h0000_0D01);
    bus.irq[1] = 1'b1;
    tick();
    chk_reg("c_ip1", 5'd13, 32'h0000_0200);
    chk_no_req("c_masked", 3);
    vec_q.push_back(32'h110);
    wr(5'd12, 32'h0000_0F01);
    wait_req("c_unmasked", 2);
    do_ack(32'h800);
    bus.irq[1] = 1'b0;
    do_eret();

    // Fill the EPC stack with nested lines 3..0
    for (int l = 3; l >= 0; l--) begin
      wr(5'd12, 32'h0000_0F01);
      bus.irq[l] = 1'b1;
      vec_q.push_back(32'h100 + 32'(l) * 32'h10);
      wait_req($sformatf("d_fill%0d", l), 4);
      do_ack(32'h1000 * 32'(4 - l));
      bus.irq[l] = 1'b0;
    end
    wr(5'd12, 32'h0000_0F01);
    chk_reg("d_full_status", 5'd12, 32'h0004_0F01);
    chk_reg("d_full_cause", 5'd13, 32'h000F_0000);
    chk("d_full_epc", bus.EPC_out, 32'h4000);
    bus.irq[3] = 1'b1;
    tick();
    chk_reg("d_pend3", 5'd13, 32'h000F_0800);
    chk_no_req("d_blocked", 4);
    bus.irq[3] = 1'b0;
    wr(5'd13, 32'h0);
    chk_reg("d_sw_clear", 5'd13, 32'h000F_0000);
    for (int j = 0; j < 4; j++) begin
      do_eret();
      chk($sformatf("d_pop%0d", j), bus.EPC_out, 32'h3000 - 32'h1000 * 32'(j));
    end
    chk_reg("d_empty_cause", 5'd13, 32'h0);
    do_eret();
    chk_reg("d_stkerr", 5'd13, 32'h8000_0000);
    chk("d_stkerr_epc", bus.EPC_out, 32'h0);
    chk_reg("d_stkerr_status", 5'd12, 32'h0000_0F01);

    // Asynchronous reset in the middle of a request
    bus.irq[0] = 1'b1;
    vec_q.push_back(32'h100);
    wait_req("e_vector", 4);
    #2;
    clr_n   = 1'b0;
    bus.irq = '0;
    #1;
    chk("e_async_req", 32'(bus.int_req), 32'h0);
    chk("e_async_vec", bus.int_vector, 32'h0);
    tick();
    clr_n = 1'b1;
    chk_reg("e_status", 5'd12, 32'h0000_0F00);
    chk_reg("e_cause", 5'd13, 32'h0);
    do_ack(32'h9000);
    chk("e_ack_ignored_epc", bus.EPC_out, 32'h0);
    chk_reg("e_ack_ignored_status", 5'd12, 32'h0000_0F00);
    chk("e_ack_ignored_req", 32'(bus.int_req), 32'h0);

    if (vec_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d vectors never requested", vec_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_nested_intc.md
Name: cp0_nested_intc

Overview:
- Parametrised successor to the single-request CP0 coprocessor-0 block.
- Adds NUM_IRQ prioritised interrupt lines, per-line masking, sticky pending bits, an in-service register and an EPC stack of depth EPC_DEPTH for nested interrupts.
- Uses a two-state request/acknowledge handshake with the CPU pipeline.
- Sits beside the register file; the CPU reads and writes it through mfc0/mtc0 ports.

Parameters:
WIDTH, 32, data/address width
NUM_IRQ, 4, interrupt lines (1..8); line 0 is highest priority
EPC_DEPTH, 4, EPC stack entries (power of two, >=2)
VEC_BASE, 32'h0000_0100, handler vector of line 0
VEC_STRIDE, 32'h0000_0010, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE

Ports:
clk  in  1  clock, rising edge
clr_n  in  1  asynchronous active-low reset
R_in  in  5  read register number
R_out  out  WIDTH  combinational read data
W_in  in  5  write register number
Din  in  WIDTH  write data
WE  in  1  write enable
irq  in  NUM_IRQ  level interrupt lines, already synchronous to clk
int_req  out  1  interrupt request to CPU
int_vector  out  WIDTH  handler address; valid while int_req=1
int_ack  in  1  CPU accepts the request; EPC_in is sampled
EPC_in  in  WIDTH  return address pushed on ack
eret  in  1  return from handler, one-cycle pulse
EPC_out  out  WIDTH  top of EPC stack; 0 when empty

Behaviour:
- Register map:
  - 12 = Status: bit0 IE; bits[8+NUM_IRQ-1:8] IM (mask); bits[19:16] stack depth, read-only.
  - 13 = Cause: bits[8+NUM_IRQ-1:8] IP (pending); bits[23:16] ISR (in-service), read-only; bit31 STKERR (sticky).
  - 14 = EPC: top of stack; a write replaces the top entry, ignored when empty.
  - Any other R_in reads 0. Unimplemented bits read 0.
- Reset (clr_n=0, asynchronous):
  - IE=0, IM=all 1, IP=0, ISR=0, STKERR=0, stack empty.
  - int_req=0, int_vector=0, EPC_out=0, state=IDLE.
  - Reset during REQ aborts the request; no push occurs.
- Pending capture:
  - irq_prev is registered each cycle.
  - A rising edge on irq[i] sets IP[i] at the next clk edge.
  - IP[i] clears only on acceptance of line i, or when software writes 0 via Cause.
  - If a hardware set and a software clear hit the same bit in the same cycle, the set wins.
- Eligibility:
  - cand = IP & IM & ~ISR. Highest = lowest set index in cand.
  - An interrupt is eligible when IE=1, cand != 0, highest index < lowest set ISR index (or ISR=0), and depth < EPC_DEPTH.
- FSM, two states:
  - IDLE: when eligible, latch index k, drive int_vector=vector(k), set int_req=1, go to REQ at the next edge.
  - REQ: int_req and int_vector are held stable until int_ack. Changes to IE/IM/IP meanwhile do not withdraw the request.
  - On int_ack in REQ: push EPC_in, clear IP[k], set ISR[k], clear IE, deassert int_req, return to IDLE.
  - Result: minimum one-cycle gap between requests; request-to-ack latency is set by the CPU.
- eret (any state):
  - Pops the stack, clears the lowest set ISR bit, sets IE=1.
  - If the stack is empty: no pop, set STKERR, IE=1.
  - If eret and int_ack coincide, ack is processed and eret is ignored, with STKERR set.
- Write conflicts: a hardware IE change (ack/eret) overrides a same-cycle software write to the IE bit.
- Stack:
  - Push beyond EPC_DEPTH cannot happen, because eligibility blocks it.
  - EPC_out = top entry, combinational from the stack registers.

Test Plan:
- Reset, then set IE=1 via Status write; pulse irq[2] -> IP[2]=1 next cycle; int_req=1 with int_vector=32'h120; ack with EPC_in=32'h400 -> EPC_out=32'h400, ISR=4'b0100, IE=0, int_req=0.
- Simultaneous rising irq[1] and irq[3] with IE=1 -> vector 32'h110 first; after eret, vector 32'h130 is requested.
- Nesting: servicing line 2, software sets IE=1, irq[0] rises -> request vector 32'h100; ack with 32'h500 -> depth 2; eret -> EPC_out=32'h400, ISR=4'b0100.
- IM[1]=0 with irq[1] rising -> IP[1]=1 but no int_req; set IM[1]=1 -> int_req asserted within 2 cycles.
- Fill the stack to EPC_DEPTH=4 with nested acks -> no further int_req despite pending bits; eret with empty stack -> STKERR=1, EPC_out=0.
- Assert clr_n=0 mid-REQ -> int_req=0 immediately (asynchronous); all registers at reset values; a later ack is ignored.
